// File: rtl/multiword_add_sequencer.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per cycle with a rippled carry.
// Optional subtract mode when MWADD_SUB_EN is defined; it adds input iSub.
module multiword_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
`ifdef MWADD_SUB_EN
  input  logic             iSub,
`endif
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oBusy
);

  // state | meaning
  // IDLE  | waiting for a request, oReady high
  // BUSY  | adding one chunk per edge, k = chunk index
  // DONE  | result held on oS/oC with oValid until iReady

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, stateNext;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] aReg, bReg, sumReg;
  logic             carryReg;
  logic [CHUNK:0]   chunkSum;
  logic             doSub;

`ifdef MWADD_SUB_EN
  assign doSub = iSub;
`else
  assign doSub = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    oReady    = 1'b0;
    oValid    = 1'b0;
    oBusy     = 1'b1;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        if (iValid) stateNext = BUSY;
      end
      BUSY: begin
        if (k == K_LAST) stateNext = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operands shift down one chunk per edge, so the active chunk always sits at bit 0;
  // the sum shifts in from the top and is fully aligned after N edges.
  assign chunkSum = {1'b0, aReg[CHUNK-1:0]} + {1'b0, bReg[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carryReg};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      aReg     <= '0;
      bReg     <= '0;
      sumReg   <= '0;
      carryReg <= 1'b0;
      k        <= '0;
    end else if (state == IDLE && iValid) begin
      aReg     <= iA;
      bReg     <= doSub ? ~iB : iB;
      carryReg <= doSub ? 1'b1 : iC;
      k        <= '0;
    end else if (state == BUSY) begin
      aReg     <= aReg >> CHUNK;
      bReg     <= bReg >> CHUNK;
      sumReg   <= {chunkSum[CHUNK-1:0], sumReg[WIDTH-1:CHUNK]};
      carryReg <= chunkSum[CHUNK];
      if (k != K_LAST) k <= k + 1'b1;
    end
  end

  assign oS = sumReg;
  assign oC = carryReg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (WIDTH=64, CHUNK=16) with a result scoreboard.
// Subtract cases are exercised when MWADD_SUB_EN is defined.
module tb_multiword_add_sequencer;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int N     = WIDTH / CHUNK;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iValid = 1'b0;
  logic             oReady;
  logic [WIDTH-1:0] iA = '0;
  logic [WIDTH-1:0] iB = '0;
  logic             iC = 1'b0;
`ifdef MWADD_SUB_EN
  logic             iSub = 1'b0;
`endif
  logic             oValid;
  logic             iReady = 1'b0;
  logic [WIDTH-1:0] oS;
  logic             oC;
  logic             oBusy;

  int nChecks = 0;
  int nFail = 0;
  logic [WIDTH:0] sbQ[$];

  multiword_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iC(iC),
`ifdef MWADD_SUB_EN
    .iSub(iSub),
`endif
    .oValid(oValid), .iReady(iReady), .oS(oS), .oC(oC), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic c, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic waitValid(output int cnt);
    cnt = 0;
    while (oValid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic runReq(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic sub);
    int cnt;
    logic [WIDTH:0] e;
    cnt = 0;
    while (oReady !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    iA = a; iB = b; iC = c;
`ifdef MWADD_SUB_EN
    iSub = sub;
`endif
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    sbQ.push_back(model(a, b, c, sub));
    waitValid(cnt);
    check({tag, "_latency"}, cnt, N);
    e = sbQ.pop_front();
    check({tag, "_sum"}, oS, e[WIDTH-1:0]);
    check({tag, "_carry"}, oC, e[WIDTH]);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check({tag, "_valid_drop"}, oValid, 1'b0);
  endtask

  initial begin
    int cnt, cyc, acc, res, firstAcc, secAcc;
    logic [WIDTH:0] e;
    logic sawValid, preAcc, preOut, obsC;
    logic [WIDTH-1:0] obsS;

    // Reset values
    repeat (3) tick();
    check("rst_ready", oReady, 1'b1);
    check("rst_valid", oValid, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_sum", oS, '0);
    check("rst_carry", oC, 1'b0);
    iRst_n = 1'b1;
    tick();

    runReq("ripple", {WIDTH{1'b1}}, 64'd1, 1'b0, 1'b0);
    runReq("ripple_cin", {WIDTH{1'b1}}, 64'd0, 1'b1, 1'b0);
    runReq("chunk_edge", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      runReq("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);

    // Backpressure: result held while iReady=0 and new requests are ignored
    iA = 64'h1234; iB = 64'h1; iC = 1'b0; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    sbQ.push_back(model(64'h1234, 64'h1, 1'b0, 1'b0));
    waitValid(cnt);
    check("bp_latency", cnt, N);
    e = sbQ.pop_front();
    for (int i = 0; i < 5; i++) begin
      iA = {$urandom, $urandom}; iB = {$urandom, $urandom};
      iValid = (i % 2 == 0);
      tick();
      check("bp_sum", oS, e[WIDTH-1:0]);
      check("bp_carry", oC, e[WIDTH]);
      check("bp_valid", oValid, 1'b1);
      check("bp_ready", oReady, 1'b0);
    end
    check("bp_sum_const", oS, 64'h1235);
    iValid = 1'b0; iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("bp_release", oValid, 1'b0);
    tick(); tick();
    check("bp_no_second_accept", oBusy, 1'b0);

    // Mid-operation reset at k=2
    iA = 64'h9; iB = 64'h9; iC = 1'b1; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    tick(); tick();
    check("midrst_busy_before", oBusy, 1'b1);
    iRst_n = 1'b0;
    #1;
    check("midrst_ready", oReady, 1'b1);
    check("midrst_valid", oValid, 1'b0);
    check("midrst_busy", oBusy, 1'b0);
    check("midrst_sum", oS, '0);
    check("midrst_carry", oC, 1'b0);
    tick();
    iRst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oValid === 1'b1) sawValid = 1'b1;
    end
    check("midrst_no_valid", sawValid, 1'b0);
    runReq("after_rst", 64'd3, 64'd4, 1'b1, 1'b0);
    check("after_rst_idle", oBusy, 1'b0);

    // Back-to-back with iValid and iReady held high
    iA = 64'hDEAD_BEEF_0000_FFFF; iB = 64'h0000_0001_FFFF_0001; iC = 1'b1;
    iValid = 1'b1; iReady = 1'b1;
    cyc = 0; acc = 0; res = 0; firstAcc = 0; secAcc = 0;
    while (res < 2 && cyc < 40) begin
      preAcc = oReady && iValid;
      preOut = oValid && iReady;
      obsS = oS; obsC = oC;
      tick();
      cyc++;
      if (preAcc) begin
        sbQ.push_back(model(iA, iB, iC, 1'b0));
        acc++;
        if (acc == 1) begin
          firstAcc = cyc;
          iA = 64'h8000_0000_0000_0000; iB = 64'h8000_0000_0000_0001; iC = 1'b0;
        end else begin
          secAcc = cyc;
          iValid = 1'b0;
        end
      end
      if (preOut) begin
        e = sbQ.pop_front();
        check("b2b_sum", obsS, e[WIDTH-1:0]);
        check("b2b_carry", obsC, e[WIDTH]);
        res++;
      end
    end
    iValid = 1'b0; iReady = 1'b0;
    check("b2b_results", res, 2);
    check("b2b_spacing", secAcc - firstAcc, N + 2);

`ifdef MWADD_SUB_EN
    runReq("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1);
    runReq("sub_noborrow", 64'd7, 64'd5, 1'b0, 1'b1);
    runReq("sub_equal", 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: bits added per cycle. WIDTH SHALL be an integer multiple of CHUNK. N = WIDTH/CHUNK SHALL be >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-low reset. Polarity and synchronicity are fixed.
REQ-004 iClk  in  1  sole clock; all state changes on its rising edge.
REQ-005 iRst_n  in  1  asynchronous active-low reset.
REQ-006 iValid  in  1  request valid.
REQ-007 oReady  out  1  request accepted this edge when iValid=1.
REQ-008 iA, iB  in  WIDTH  operands.
REQ-009 iC  in  1  carry-in.
REQ-010 oValid  out  1  result valid.
REQ-011 iReady  in  1  consumer ready for the result.
REQ-012 oS  out  WIDTH  sum.
REQ-013 oC  out  1  carry-out of bit WIDTH-1.
REQ-014 oBusy  out  1  high in any state except IDLE.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-016 IDLE: oReady=1. On an edge with iValid=1, SHALL capture iA, iB and iC, clear chunk counter k to 0, load the carry register with iC, and go to BUSY.
REQ-017 BUSY: oReady=0. Each edge SHALL add chunk k of A, chunk k of B and the carry register as a CHUNK-bit addition, write the sum into result bits [k*CHUNK +: CHUNK], and load the chunk carry-out into the carry register.
REQ-018 BUSY: when k = N-1, SHALL go to DONE, with oC equal to the final carry; otherwise k increments.
REQ-019 Latency: oValid SHALL rise exactly N edges after the accepting edge (4 for the defaults).
REQ-020 DONE: oValid=1, oReady=0. oS and oC SHALL stay stable until an edge with iReady=1. That edge SHALL return the FSM to IDLE with oValid=0.
REQ-021 iValid while not in IDLE SHALL be ignored; no request is queued.
REQ-022 Minimum spacing between accepting edges SHALL be N+2 cycles. There is no IDLE bypass.
REQ-023 oS and oC are checked only while oValid=1. They SHALL never carry X after reset.
REQ-024 Arithmetic is modulo 2^WIDTH. A carry SHALL ripple correctly across every chunk boundary, including an all-ones operand plus 1.

Reset
REQ-025 While iRst_n=0: state=IDLE, oReady=1, oValid=0, oBusy=0, oS=0, oC=0, k=0, carry register=0.
REQ-026 Reset asserted in BUSY or DONE SHALL abandon the operation with no oValid pulse. The first request after release SHALL compute correctly.

Configuration
REQ-027 Macro MWADD_SUB_EN: when defined, SHALL add input iSub (1 bit), captured with the operands.
REQ-028 With MWADD_SUB_EN and captured iSub=1: SHALL add ~B chunkwise, load the carry register with 1 and ignore iC. oC = 1 means no borrow (A >= B unsigned).
REQ-029 Without MWADD_SUB_EN: the iSub port SHALL be absent and the block SHALL add only.

Verification (WIDTH=64, CHUNK=16)
REQ-030 Reset: hold iRst_n=0 -> oReady=1, oValid=0, oBusy=0, oS=0, oC=0.
REQ-031 Full ripple: iA=0xFFFF_FFFF_FFFF_FFFF, iB=1, iC=0 -> oS=0, oC=1, oValid exactly 4 edges after accept.
REQ-032 Backpressure: iA=0x1234, iB=0x1, iReady=0 for 5 cycles, iValid pulsed meanwhile -> oS=0x1235 stable, oValid=1, oReady=0, no second accept.
REQ-033 Mid-op reset: iRst_n=0 for 1 cycle at k=2 -> reset values and no oValid. Then iA=3, iB=4, iC=1 -> oS=8, oC=0.
REQ-034 Back-to-back: iValid and iReady held high, two requests -> second accepting edge 6 cycles after the first, both results correct.
REQ-035 MWADD_SUB_EN: iA=5, iB=7, iSub=1 -> oS=0xFFFF_FFFF_FFFF_FFFE, oC=0. iA=7, iB=5 -> oS=2, oC=1.
